// File: rtl/mem_pkg.sv
// mem_pkg: default geometry for the single-port synchronous SRAM model
package mem_pkg;
  localparam int MEM_ADDR_W = 7;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;
endpackage

// File: rtl/mem_1mb_32bit.sv
// mem_1mb_32bit: single-port sync SRAM with registered read; define MEM_CLEAR_ON_RST_EN to zero the array on rst
module mem_1mb_32bit
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (cs && !wr) rd_data <= mem[addr];
    if (!rst && cs && wr) mem[addr] <= wr_data;
`ifdef MEM_CLEAR_ON_RST_EN
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`endif
  end
endmodule

// File: tb/tb_mem_1mb_32bit.sv
// tb_mem_1mb_32bit: directed and randomized checks of mem_1mb_32bit against an array reference model
module tb_mem_1mb_32bit;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic          cs = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_mem [D];
  bit            m_ok  [D];
  logic [DW-1:0] m_rd = '0;
  bit            m_rd_ok = 1'b0;

  always #5 clk = ~clk;

  mem_1mb_32bit dut (
    .clk(clk), .rst(rst), .wr(wr), .cs(cs),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
  );

  // Drive one cycle, let the edge happen, then advance the reference model
  task automatic step(input bit r, input bit c, input bit w, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; cs = c; wr = w; addr = a[AW-1:0]; wr_data = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_rd = '0;
      m_rd_ok = 1'b1;
`ifdef MEM_CLEAR_ON_RST_EN
      for (int i = 0; i < D; i++) begin
        m_mem[i] = '0;
        m_ok[i] = 1'b1;
      end
`endif
    end else if (c && w) begin
      m_mem[a] = d;
      m_ok[a] = 1'b1;
    end else if (c) begin
      m_rd = m_mem[a];
      m_rd_ok = m_ok[a];
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    tests++;
    if (rd_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_rd: got %h want 00000000", rd_data);
    end
`ifdef MEM_CLEAR_ON_RST_EN
    step(0, 1, 0, 5, 0);
    tests++;
    if (rd_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_clear_a5: got %h want 00000000", rd_data);
    end
`endif
  endtask

  task automatic test_write_read();
    step(0, 1, 1, 29, 29);
    step(0, 1, 1, 27, 27);
    step(0, 1, 1, 28, 30);
    step(0, 1, 1, 19, 15);
    step(0, 1, 0, 27, 0);
    tests++;
    if (rd_data !== 32'd27) begin
      fails++;
      $display("FAIL read_a27: got %h want %h", rd_data, 32'd27);
    end
    step(0, 1, 0, 28, 0);
    tests++;
    if (rd_data !== 32'd30) begin
      fails++;
      $display("FAIL read_a28: got %h want %h", rd_data, 32'd30);
    end
  endtask

  task automatic test_idle();
    step(0, 0, 1, 19, 99);
    tests++;
    if (rd_data !== 32'd30) begin
      fails++;
      $display("FAIL idle_hold: got %h want %h", rd_data, 32'd30);
    end
    step(0, 0, 0, 3, 7);
    tests++;
    if (rd_data !== 32'd30) begin
      fails++;
      $display("FAIL idle_hold2: got %h want %h", rd_data, 32'd30);
    end
    step(0, 1, 0, 19, 0);
    tests++;
    if (rd_data !== 32'd15) begin
      fails++;
      $display("FAIL idle_nowrite_a19: got %h want %h", rd_data, 32'd15);
    end
  endtask

  task automatic test_boundary();
    step(0, 1, 1, 127, 32'hFFFF_FFFF);
    step(0, 1, 1, 0, 32'hA5A5_A5A5);
    step(0, 1, 0, 127, 0);
    tests++;
    if (rd_data !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL read_a127: got %h want ffffffff", rd_data);
    end
    step(0, 1, 0, 0, 0);
    tests++;
    if (rd_data !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL read_a0: got %h want a5a5a5a5", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 1, 10, 1);
    step(0, 1, 0, 10, 0);
    tests++;
    if (rd_data !== 32'd1) begin
      fails++;
      $display("FAIL b2b_read: got %h want %h", rd_data, 32'd1);
    end
    step(0, 1, 1, 10, 2);
    tests++;
    if (rd_data !== 32'd1) begin
      fails++;
      $display("FAIL b2b_write_hold: got %h want %h", rd_data, 32'd1);
    end
    step(0, 1, 0, 10, 0);
    tests++;
    if (rd_data !== 32'd2) begin
      fails++;
      $display("FAIL b2b_reread: got %h want %h", rd_data, 32'd2);
    end
  endtask

  task automatic test_reset_during_read();
    logic [DW-1:0] want;
    step(1, 1, 0, 28, 0);
    tests++;
    if (rd_data !== 32'd0) begin
      fails++;
      $display("FAIL rst_over_read: got %h want 00000000", rd_data);
    end
`ifdef MEM_CLEAR_ON_RST_EN
    want = 32'd0;
`else
    want = 32'd30;
`endif
    step(0, 1, 0, 28, 0);
    tests++;
    if (rd_data !== want) begin
      fails++;
      $display("FAIL post_rst_a28: got %h want %h", rd_data, want);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, D - 1)), $urandom);
      if (m_rd_ok) begin
        tests++;
        if (rd_data !== m_rd) begin
          fails++;
          $display("FAIL random_%0d: got %h want %h", n, rd_data, m_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_idle();
    test_boundary();
    test_back_to_back();
    test_reset_during_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
